// File: rtl/fp_pkg.sv
// Shared FPU op codes, format codes, FSM encoding and field widths for the FP issue front end.
package fp_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned CNT_W = 4;

    localparam logic [OP_W-1:0] OP_ADDSUB = 4'h0;
    localparam logic [OP_W-1:0] OP_MUL    = 4'h1;
    localparam logic [OP_W-1:0] OP_DIV    = 4'h2;
    localparam logic [OP_W-1:0] OP_MINMAX = 4'h3;
    localparam logic [OP_W-1:0] OP_CMP    = 4'h4;
    localparam logic [OP_W-1:0] OP_SGNJ   = 4'h5;
    localparam logic [OP_W-1:0] OP_CVT    = 4'h6;
    localparam logic [OP_W-1:0] OP_INTCVT = 4'h7;

    localparam logic FMT_S = 1'b0;
    localparam logic FMT_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/fp_lat_lut.sv
// Op code to settle-latency lookup (returned as latency minus one) plus illegal-op detect.
module fp_lat_lut
    import fp_pkg::*;
#(
    parameter int unsigned LAT_ADDSUB = 3,
    parameter int unsigned LAT_MUL    = 4,
    parameter int unsigned LAT_DIV    = 12,
    parameter int unsigned LAT_MISC   = 1
) (
    input  logic [OP_W-1:0]  i_op,
    output logic [CNT_W-1:0] o_lat_m1_c,
    output logic             o_illegal_c
);

    // Codes 1000..1111 are illegal; every legal code not listed takes the misc latency.
    always_comb begin
        o_lat_m1_c  = CNT_W'(LAT_MISC - 1);
        o_illegal_c = i_op[OP_W-1];
        case (i_op)
            OP_ADDSUB: o_lat_m1_c = CNT_W'(LAT_ADDSUB - 1);
            OP_MUL:    o_lat_m1_c = CNT_W'(LAT_MUL - 1);
            OP_DIV:    o_lat_m1_c = CNT_W'(LAT_DIV - 1);
            default:   o_lat_m1_c = CNT_W'(LAT_MISC - 1);
        endcase
    end

endmodule

// File: rtl/fp_issue_ctrl.sv
// FP issue controller: accepts one op, drives the FPU, waits its settle time, returns the result.
module fp_issue_ctrl
    import fp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LAT_ADDSUB = 3,
    parameter int unsigned LAT_MUL    = 4,
    parameter int unsigned LAT_DIV    = 12,
    parameter int unsigned LAT_MISC   = 1
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_req_valid,
    output logic                  out_req_ready,
    input  logic [OP_W-1:0]       in_req_op,
    input  logic                  in_req_fmt,
    input  logic [DATA_WIDTH-1:0] in_req_rs1,
    input  logic [DATA_WIDTH-1:0] in_req_rs2,
    input  logic [RD_W-1:0]       in_req_rd,
    input  logic                  in_flush,
    output logic [DATA_WIDTH-1:0] out_fpu_rs1,
    output logic [DATA_WIDTH-1:0] out_fpu_rs2,
    output logic [OP_W-1:0]       out_fpu_op,
    output logic                  out_fpu_fmt,
    input  logic [DATA_WIDTH-1:0] in_fpu_result,
    output logic                  out_rsp_valid,
    input  logic                  in_rsp_ready,
    output logic [DATA_WIDTH-1:0] out_rsp_data,
    output logic [RD_W-1:0]       out_rsp_rd,
    output logic                  out_rsp_illegal,
    output logic                  out_busy
);

    state_e                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_fpu_rs1;
    logic [DATA_WIDTH-1:0] r_fpu_rs2;
    logic [OP_W-1:0]       r_fpu_op;
    logic                  r_fpu_fmt;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [RD_W-1:0]       r_rsp_rd;
    logic                  r_rsp_valid;
    logic                  r_rsp_illegal;
    logic                  r_live;

    logic [CNT_W-1:0]      w_lat_m1;
    logic                  w_illegal;
    logic                  w_req_ready;
    logic                  w_accept;

    fp_lat_lut #(
        .LAT_ADDSUB (LAT_ADDSUB),
        .LAT_MUL    (LAT_MUL),
        .LAT_DIV    (LAT_DIV),
        .LAT_MISC   (LAT_MISC)
    ) u_lat_lut (
        .i_op        (in_req_op),
        .o_lat_m1_c  (w_lat_m1),
        .o_illegal_c (w_illegal)
    );

    // Ready only in IDLE, never in a flush cycle, and not until the first clock after reset.
    assign w_req_ready = r_live && (r_state == ST_IDLE) && !in_flush;
    assign w_accept    = w_req_ready && in_req_valid;

    // Sequencer: IDLE -> EXEC (settle countdown) -> RESP (hold until consumed); flush wins.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_fpu_rs1     <= '0;
            r_fpu_rs2     <= '0;
            r_fpu_op      <= '0;
            r_fpu_fmt     <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_rd      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_illegal <= 1'b0;
            r_live        <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (in_flush) begin
                r_state       <= ST_IDLE;
                r_rsp_valid   <= 1'b0;
                r_rsp_illegal <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_fpu_rs1 <= in_req_rs1;
                            r_fpu_rs2 <= in_req_rs2;
                            r_fpu_op  <= in_req_op;
                            r_fpu_fmt <= in_req_fmt;
                            r_rsp_rd  <= in_req_rd;
                            if (w_illegal) begin
                                r_rsp_data    <= '0;
                                r_rsp_illegal <= 1'b1;
                                r_rsp_valid   <= 1'b1;
                                r_state       <= ST_RESP;
                            end else begin
                                r_cnt   <= w_lat_m1;
                                r_state <= ST_EXEC;
                            end
                        end
                    end
                    ST_EXEC: begin
                        if (r_cnt == '0) begin
                            r_rsp_data    <= in_fpu_result;
                            r_rsp_illegal <= 1'b0;
                            r_rsp_valid   <= 1'b1;
                            r_state       <= ST_RESP;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    ST_RESP: begin
                        if (in_rsp_ready) begin
                            r_rsp_valid <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign out_req_ready   = w_req_ready;
    assign out_fpu_rs1     = r_fpu_rs1;
    assign out_fpu_rs2     = r_fpu_rs2;
    assign out_fpu_op      = r_fpu_op;
    assign out_fpu_fmt     = r_fpu_fmt;
    assign out_rsp_valid   = r_rsp_valid;
    assign out_rsp_data    = r_rsp_data;
    assign out_rsp_rd      = r_rsp_rd;
    assign out_rsp_illegal = r_rsp_illegal;
    assign out_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl: deadline-based behavioural model, per-cycle compare, directed and random stimulus.
module tb_fp_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_req_valid = 1'b0;
    logic        out_req_ready;
    logic [3:0]  in_req_op = '0;
    logic        in_req_fmt = 1'b0;
    logic [63:0] in_req_rs1 = '0;
    logic [63:0] in_req_rs2 = '0;
    logic [4:0]  in_req_rd = '0;
    logic        in_flush = 1'b0;
    logic [63:0] out_fpu_rs1;
    logic [63:0] out_fpu_rs2;
    logic [3:0]  out_fpu_op;
    logic        out_fpu_fmt;
    logic [63:0] in_fpu_result = '0;
    logic        out_rsp_valid;
    logic        in_rsp_ready = 1'b1;
    logic [63:0] out_rsp_data;
    logic [4:0]  out_rsp_rd;
    logic        out_rsp_illegal;
    logic        out_busy;

    always #5 clk = ~clk;

    fp_issue_ctrl #(
        .DATA_WIDTH (64),
        .LAT_ADDSUB (3),
        .LAT_MUL    (4),
        .LAT_DIV    (12),
        .LAT_MISC   (1)
    ) dut (
        .in_clk          (clk),
        .in_rst_n        (rst_n),
        .in_req_valid    (in_req_valid),
        .out_req_ready   (out_req_ready),
        .in_req_op       (in_req_op),
        .in_req_fmt      (in_req_fmt),
        .in_req_rs1      (in_req_rs1),
        .in_req_rs2      (in_req_rs2),
        .in_req_rd       (in_req_rd),
        .in_flush        (in_flush),
        .out_fpu_rs1     (out_fpu_rs1),
        .out_fpu_rs2     (out_fpu_rs2),
        .out_fpu_op      (out_fpu_op),
        .out_fpu_fmt     (out_fpu_fmt),
        .in_fpu_result   (in_fpu_result),
        .out_rsp_valid   (out_rsp_valid),
        .in_rsp_ready    (in_rsp_ready),
        .out_rsp_data    (out_rsp_data),
        .out_rsp_rd      (out_rsp_rd),
        .out_rsp_illegal (out_rsp_illegal),
        .out_busy        (out_busy)
    );

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    // Model: one outstanding op, response visible from cycle m_due until consumed.
    bit          m_busy = 0;
    bit          m_live = 0;
    bit          m_ill  = 0;
    bit          m_vld_now = 0;
    int          m_due  = 0;
    logic [63:0] m_data = '0;
    logic [63:0] m_rs1  = '0;
    logic [63:0] m_rs2  = '0;
    logic [3:0]  m_op   = '0;
    logic        m_fmt  = 1'b0;
    logic [4:0]  m_rd   = '0;

    function automatic int lat_of(input logic [3:0] op);
        case (op)
            4'd0:    return 3;
            4'd1:    return 4;
            4'd2:    return 12;
            default: return 1;
        endcase
    endfunction

    // Stand-in FPU: real double multiply for mul.d, a fixed scramble otherwise.
    function automatic logic [63:0] fpu_f(input logic [3:0] op, input logic fmt,
                                          input logic [63:0] a, input logic [63:0] b);
        if (op == 4'd1 && fmt)
            return $realtobits($bitstoreal(a) * $bitstoreal(b));
        return (a ^ {b[31:0], b[63:32]}) + 64'(op) + (fmt ? 64'h100 : 64'h0);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_live = 0; m_ill = 0; m_due = 0; m_data = '0;
            m_rs1 = '0; m_rs2 = '0; m_op = '0; m_fmt = 1'b0; m_rd = '0;
        end else begin
            m_vld_now = m_busy && (cyc >= m_due);
            if (in_flush) begin
                m_busy = 0;
            end else if (!m_busy) begin
                if (m_live && in_req_valid) begin
                    m_rs1 = in_req_rs1; m_rs2 = in_req_rs2; m_op = in_req_op;
                    m_fmt = in_req_fmt; m_rd = in_req_rd;
                    m_ill  = (in_req_op >= 4'd8);
                    m_data = m_ill ? 64'h0 : fpu_f(in_req_op, in_req_fmt, in_req_rs1, in_req_rs2);
                    m_due  = m_ill ? cyc + 1 : cyc + 1 + lat_of(in_req_op);
                    m_busy = 1;
                end
            end else if (m_vld_now && in_rsp_ready) begin
                m_busy = 0;
            end
            m_live = 1;
            cyc++;
        end
    end

    // FPU output is garbage until the op's last settle cycle.
    always @(negedge clk) begin
        if (m_busy && !m_ill && (cyc >= m_due - 1))
            in_fpu_result = fpu_f(m_op, m_fmt, m_rs1, m_rs2);
        else
            in_fpu_result = {$urandom, $urandom};
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            chk("req_ready", 64'(out_req_ready), 64'(m_live && !m_busy && !in_flush));
            chk("busy", 64'(out_busy), 64'(m_busy));
            chk("rsp_valid", 64'(out_rsp_valid), 64'(m_busy && (cyc >= m_due)));
            if (m_busy && (cyc >= m_due)) begin
                chk("rsp_data", out_rsp_data, m_data);
                chk("rsp_rd", 64'(out_rsp_rd), 64'(m_rd));
                chk("rsp_illegal", 64'(out_rsp_illegal), 64'(m_ill));
            end
            chk("fpu_rs1", out_fpu_rs1, m_rs1);
            chk("fpu_rs2", out_fpu_rs2, m_rs2);
            chk("fpu_op", 64'(out_fpu_op), 64'(m_op));
            chk("fpu_fmt", 64'(out_fpu_fmt), 64'(m_fmt));
        end
    end

    task automatic issue(input logic [3:0] op, input logic fmt, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, output int acc);
        @(negedge clk);
        in_req_valid = 1'b1; in_req_op = op; in_req_fmt = fmt;
        in_req_rs1 = a; in_req_rs2 = b; in_req_rd = rd;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (out_req_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) chk("accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        in_req_valid = 1'b0;
    endtask

    // Called at a falling edge; returns the first cycle with a valid response.
    task automatic wait_rsp(output int v);
        v = -1;
        for (int i = 0; i < 300; i++) begin
            #3;
            if (out_rsp_valid) begin
                v = cyc;
                break;
            end
            @(negedge clk);
        end
        if (v < 0) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int k, k2, v;

        repeat (3) @(negedge clk);
        #3;
        chk("ready_in_reset", 64'(out_req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #3;
        chk("ready_after_release", 64'(out_req_ready), 64'd1);

        // Multiply 2.0 * 3.0
        in_rsp_ready = 1'b1;
        issue(4'd1, 1'b1, 64'h4000000000000000, 64'h4008000000000000, 5'd5, k);
        wait_rsp(v);
        chk("mul_latency", 64'(v - k), 64'd5);
        chk("mul_data", out_rsp_data, 64'h4018000000000000);
        chk("mul_rd", 64'(out_rsp_rd), 64'd5);
        chk("mul_illegal", 64'(out_rsp_illegal), 64'd0);

        // Divide with the consumer stalling
        @(negedge clk);
        in_rsp_ready = 1'b0;
        issue(4'd2, 1'b1, 64'h4022000000000000, 64'h4008000000000000, 5'd9, k);
        wait_rsp(v);
        chk("div_latency", 64'(v - k), 64'd13);
        repeat (3) begin
            @(negedge clk); #3;
            chk("div_stall_ready", 64'(out_req_ready), 64'd0);
            chk("div_stall_valid", 64'(out_rsp_valid), 64'd1);
            chk("div_stall_rd", 64'(out_rsp_rd), 64'd9);
        end
        in_rsp_ready = 1'b1;
        @(negedge clk); #3;
        chk("div_done_valid", 64'(out_rsp_valid), 64'd0);
        chk("div_done_ready", 64'(out_req_ready), 64'd1);

        // Illegal op
        issue(4'b1010, 1'b0, 64'h1234, 64'h5678, 5'd31, k);
        wait_rsp(v);
        chk("ill_latency", 64'(v - k), 64'd1);
        chk("ill_data", out_rsp_data, 64'd0);
        chk("ill_flag", 64'(out_rsp_illegal), 64'd1);
        chk("ill_rd", 64'(out_rsp_rd), 64'd31);

        // Flush an add mid-EXEC, then a compare
        issue(4'd0, 1'b0, 64'hAAAA, 64'hBBBB, 5'd3, k);
        in_flush = 1'b1;
        @(negedge clk);
        in_flush = 1'b0;
        #3;
        chk("flush_busy", 64'(out_busy), 64'd0);
        chk("flush_valid", 64'(out_rsp_valid), 64'd0);
        chk("flush_illegal", 64'(out_rsp_illegal), 64'd0);
        issue(4'd4, 1'b0, 64'h10, 64'h0, 5'd7, k);
        wait_rsp(v);
        chk("cmp_latency", 64'(v - k), 64'd2);
        chk("cmp_data", out_rsp_data, 64'h14);

        // Request coinciding with flush in IDLE is refused
        @(negedge clk);
        in_req_valid = 1'b1; in_req_op = 4'd3; in_flush = 1'b1;
        #3;
        chk("flush_blocks_ready", 64'(out_req_ready), 64'd0);
        @(negedge clk);
        in_req_valid = 1'b0; in_flush = 1'b0;
        #3;
        chk("flush_no_accept", 64'(out_busy), 64'd0);

        // Back-to-back sgnj then add
        issue(4'd5, 1'b0, 64'h3F80, 64'h0001, 5'd12, k);
        issue(4'd0, 1'b1, 64'h2222, 64'h3333, 5'd13, k2);
        chk("b2b_accept_gap", 64'(k2 - k), 64'd3);
        wait_rsp(v);
        chk("b2b_latency", 64'(v - k2), 64'd4);
        chk("b2b_rd", 64'(out_rsp_rd), 64'd13);

        // Reset mid-EXEC
        issue(4'd2, 1'b1, 64'hFFFF, 64'hEEEE, 5'd1, k);
        repeat (3) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(out_busy), 64'd0);
        chk("rst_ready", 64'(out_req_ready), 64'd0);
        chk("rst_fpu_rs1", out_fpu_rs1, 64'd0);
        chk("rst_fpu_op", 64'(out_fpu_op), 64'd0);
        chk("rst_rsp_rd", 64'(out_rsp_rd), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #3;
        chk("rst_ready_after", 64'(out_req_ready), 64'd1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            in_req_valid = 1'($urandom_range(0, 1));
            in_req_op    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15))
                                                       : 4'($urandom_range(0, 7));
            in_req_fmt   = 1'($urandom_range(0, 1));
            in_req_rs1   = {$urandom, $urandom};
            in_req_rs2   = {$urandom, $urandom};
            in_req_rd    = 5'($urandom_range(0, 31));
            in_rsp_ready = ($urandom_range(0, 3) != 0);
            in_flush     = ($urandom_range(0, 31) == 0);
        end
        @(negedge clk);
        in_req_valid = 1'b0; in_flush = 1'b0; in_rsp_ready = 1'b1;
        repeat (20) @(negedge clk);
        #4;
        chk("drain_idle", 64'(out_busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
